ps2_key_ctrl: RTL and testbench

Sequencing controller placed between `ps2_rx` and the key decoder. Turns the raw byte stream (`dout` + `rx_done_tick`) into complete key events (make/break, standard/extended), buffers up to four events in a FIFO with a valid/ready handshake, and owns the receiver's `reset`/`rx_en` lines. A watchdog resets the receiver only when a frame stalls, replacing the free-running periodic reset.

---
 rtl/ps2_key_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// PS/2 byte sequencer: prefix FSM, 4-deep key event FIFO and receiver reset control.
// Define PS2_WATCHDOG_EN to build the stalled-frame watchdog on ps2c.
module ps2_key_ctrl #(
    parameter int TIMEOUT = 150000,
    parameter int RST_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_dout,
    output logic       rx_reset,
    output logic       rx_en,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       overflow,
    output logic       frame_err
);
    // bit1 = E0 seen, bit0 = F0 seen; doubles as {ext, brk} of the pushed event
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GOT_F0   = 2'b01,
        GOT_E0   = 2'b10,
        GOT_E0F0 = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic        rx_reset_q, rx_reset_d;
    logic        tick, is_e0, is_f0, fire;
    logic        push;
    logic [9:0]  push_data;
    logic [9:0]  mem_q [4];
    logic [9:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        overflow_q, overflow_d;
    logic        full, pop, do_push;
    logic [9:0]  head;

    assign tick  = rx_done_tick & ~rx_reset_q;
    assign is_e0 = (rx_dout == 8'hE0);
    assign is_f0 = (rx_dout == 8'hF0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            if (is_e0) begin
                state_d = GOT_E0;
            end else if (is_f0) begin
                unique case (state_q)
                    IDLE:    state_d = GOT_F0;
                    GOT_E0:  state_d = GOT_E0F0;
                    default: state_d = state_q;
                endcase
            end else begin
                state_d = IDLE;
            end
        end else if (fire) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        push      = tick & ~is_e0 & ~is_f0;
        push_data = {state_q[1], state_q[0], rx_dout};
    end

`ifdef PS2_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RST_LEN + 1);

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic          armed_q, armed_d;
    logic          sync1_q, sync2_q, prev_q;
    logic          frame_err_q;
    logic          fall;

    assign fall = prev_q & ~sync2_q & ~rx_reset_q;
    // a byte arriving on the deadline edge wins over the timeout
    assign fire = armed_q & (wd_cnt_q == CW'(TIMEOUT - 1)) & ~tick;

    always_comb begin
        armed_d  = armed_q;
        wd_cnt_d = wd_cnt_q;
        if (tick) begin
            armed_d  = (state_d != IDLE);
            wd_cnt_d = '0;
        end else if (fire) begin
            armed_d  = 1'b0;
            wd_cnt_d = '0;
        end else if (armed_q) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end else if (fall) begin
            armed_d  = 1'b1;
            wd_cnt_d = '0;
        end
    end

    always_comb begin
        rx_reset_d = 1'b0;
        rst_cnt_d  = rst_cnt_q;
        if (fire) begin
            rx_reset_d = 1'b1;
            rst_cnt_d  = RW'(RST_LEN - 1);
        end else if (rst_cnt_q != '0) begin
            rx_reset_d = 1'b1;
            rst_cnt_d  = rst_cnt_q - RW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q    <= '0;
            rst_cnt_q   <= '0;
            armed_q     <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wd_cnt_q    <= wd_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            armed_q     <= armed_d;
            sync1_q     <= ps2c;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            frame_err_q <= fire;
        end
    end

    assign frame_err = frame_err_q;
`else
    logic unused_ps2c;
    assign unused_ps2c = ps2c;
    assign fire        = 1'b0;
    assign rx_reset_d  = 1'b0;
    assign frame_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_reset_q <= 1'b1;
        else       rx_reset_q <= rx_reset_d;
    end

    assign rx_reset = rx_reset_q;
    assign rx_en    = ~rx_reset_q;

    assign key_valid = (cnt_q != 3'd0);
    assign full      = (cnt_q == 3'd4);
    assign pop       = key_valid & key_ready;
    assign do_push   = push & (~full | pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | (push & full & ~pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
        unique case ({do_push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign key_ext   = head[9];
    assign key_break = head[8];
    assign key_code  = head[7:0];
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl (TIMEOUT shortened to 100).
// Watchdog expectations follow PS2_WATCHDOG_EN.
module tb_ps2_key_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       ps2c;
    logic       rx_done_tick;
    logic [7:0] rx_dout;
    logic       rx_reset, rx_en;
    logic       key_valid, key_ready;
    logic [7:0] key_code;
    logic       key_ext, key_break;
    logic       overflow, frame_err;

    int vectors = 0;
    int errors  = 0;

    ps2_key_ctrl #(.TIMEOUT(100), .RST_LEN(4)) dut (
        .clk(clk), .reset(reset), .ps2c(ps2c),
        .rx_done_tick(rx_done_tick), .rx_dout(rx_dout),
        .rx_reset(rx_reset), .rx_en(rx_en),
        .key_valid(key_valid), .key_ready(key_ready),
        .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_dout      = b;
        step();
        rx_done_tick = 1'b0;
        rx_dout      = 8'h00;
    endtask

    task automatic chk_head(input string tag, input logic e, input logic k, input logic [7:0] c);
        chk({tag, "_valid"}, 32'(key_valid), 32'd1);
        chk({tag, "_evt"}, {22'd0, key_ext, key_break, key_code}, {22'd0, e, k, c});
    endtask

    initial begin
        int n;
        int seen;
        reset = 1'b1; ps2c = 1'b1; rx_done_tick = 1'b0;
        rx_dout = 8'h00; key_ready = 1'b1;
        step(); step();
        chk("rst_rx_reset", 32'(rx_reset), 32'd1);
        chk("rst_rx_en", 32'(rx_en), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_code", {22'd0, key_ext, key_break, key_code}, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        reset = 1'b0;
        step();
        chk("rel_rx_reset", 32'(rx_reset), 32'd0);
        chk("rel_rx_en", 32'(rx_en), 32'd1);

        send(8'h1C);
        chk_head("make1c", 1'b0, 1'b0, 8'h1C);
        step();
        chk("make1c_pop", 32'(key_valid), 32'd0);

        key_ready = 1'b0;
        send(8'hF0);
        chk("f0_alone", 32'(key_valid), 32'd0);
        send(8'h1C);
        chk_head("brk1c", 1'b0, 1'b1, 8'h1C);
        key_ready = 1'b1; step(); key_ready = 1'b0;
        chk("brk1c_pop", 32'(key_valid), 32'd0);

        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk_head("ext_make", 1'b1, 1'b0, 8'h75);
        key_ready = 1'b1; step(); key_ready = 1'b0;
        chk_head("ext_brk", 1'b1, 1'b1, 8'h75);
        key_ready = 1'b1; step(); key_ready = 1'b0;
        chk("ext_empty", 32'(key_valid), 32'd0);

        send(8'h15); send(8'h16); send(8'h1E); send(8'h25);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        send(8'h26);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk_head("full_head", 1'b0, 1'b0, 8'h15);
        key_ready = 1'b1;
        send(8'h2E);
        key_ready = 1'b0;
        chk_head("full_pp", 1'b0, 1'b0, 8'h16);
        key_ready = 1'b1;
        chk("q1", 32'(key_code), 32'h16); step();
        chk("q2", 32'(key_code), 32'h1E); step();
        chk("q3", 32'(key_code), 32'h25); step();
        chk("q4", 32'(key_code), 32'h2E); step();
        chk("q_empty", 32'(key_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        send(8'h33);
        chk_head("empty_pp", 1'b0, 1'b0, 8'h33);
        step();
        chk("empty_pp_pop", 32'(key_valid), 32'd0);

        ps2c = 1'b0;
`ifdef PS2_WATCHDOG_EN
        n = 0;
        while (n < 200 && frame_err !== 1'b1) begin
            step();
            n++;
        end
        chk("wd_latency", 32'(n), 32'd103);
        chk("wd_rx_reset", 32'(rx_reset), 32'd1);
        chk("wd_rx_en", 32'(rx_en), 32'd0);
        step();
        chk("wd_ferr_pulse", 32'(frame_err), 32'd0);
        step(); step();
        chk("wd_rst_c4", 32'(rx_reset), 32'd1);
        step();
        chk("wd_rst_end", 32'(rx_reset), 32'd0);
        chk("wd_rx_en_end", 32'(rx_en), 32'd1);
`else
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (frame_err !== 1'b0 || rx_reset !== 1'b0) seen++;
        end
        chk("nowd_quiet", 32'(seen), 32'd0);
`endif
        ps2c = 1'b1;
        send(8'h1C);
        chk_head("post_wd", 1'b0, 1'b0, 8'h1C);
        step();
        chk("post_wd_pop", 32'(key_valid), 32'd0);

        key_ready = 1'b0;
        send(8'hE0);
        repeat (110) step();
        send(8'h75);
`ifdef PS2_WATCHDOG_EN
        chk_head("stale_e0", 1'b0, 1'b0, 8'h75);
`else
        chk_head("stale_e0", 1'b1, 1'b0, 8'h75);
`endif

        send(8'h44);
        reset = 1'b1;
        #2;
        chk("mid_rst_valid", 32'(key_valid), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_rx", 32'(rx_reset), 32'd1);
        step();
        reset = 1'b0;
        step();
        chk("mid_rel_rx", 32'(rx_reset), 32'd0);
        chk("mid_rel_valid", 32'(key_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
